// File: rtl/tdm_slot_demux.sv
// tdm_slot_demux: drives a 2-bit slot select to an external 4:1 mux pair and
// reassembles the two returning serial lanes into 4-bit frames.
module tdm_slot_demux (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic clk, rst, a, b, en, view, hold, unused_bit;
  logic [1:0] sel;
  logic [2:0] sh_a, sh_b;
  logic [3:0] fr_a, fr_b;
  logic valid, chg;
  assign {unused_bit, hold, view, en, b, a, rst, clk} = io_in;
  // Slot 3 completes a frame directly from the live lane bits, so only slots 0-2 need shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
      sh_a <= '0;
      sh_b <= '0;
      fr_a <= '0;
      fr_b <= '0;
      valid <= 1'b0;
      chg <= 1'b0;
    end else begin
      valid <= 1'b0;
      chg <= 1'b0;
      if (en) begin
        sel <= sel + 2'd1;
        if (sel != 2'd3) begin
          sh_a[sel] <= a;
          sh_b[sel] <= b;
        end else if (!hold) begin
          fr_a <= {a, sh_a};
          fr_b <= {b, sh_b};
          valid <= 1'b1;
          chg <= {a, sh_a, b, sh_b} != {fr_a, fr_b};
        end
      end
    end
  end
  assign io_out = {chg, view ? fr_b : fr_a, valid, sel};
endmodule

// File: tb/tb_tdm_slot_demux.sv
// tb_tdm_slot_demux: table-driven frames, directed corner sequences and a
// randomized run checked against a slot/frame reference model.
module tb_tdm_slot_demux;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, view = 1'b0, hold = 1'b0, x7 = 1'b0;
  logic [3:0] pat_a = '0, pat_b = '0;
  logic lane_a, lane_b;
  logic [7:0] io_in, io_out;
  int total = 0, bad = 0;

  // External mux pair: lane data follows the select the DUT drives.
  assign lane_a = pat_a[io_out[1:0]];
  assign lane_b = pat_b[io_out[1:0]];
  assign io_in = {x7, hold, view, en, lane_b, lane_a, rst, clk};

  tdm_slot_demux dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  int m_slot;
  bit ca[3], cb[3];
  bit [3:0] fa, fb, na, nb;
  bit mv, mc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slot = 0;
      ca = '{0, 0, 0};
      cb = '{0, 0, 0};
      fa = 0;
      fb = 0;
      mv = 0;
      mc = 0;
    end else begin
      mv = 0;
      mc = 0;
      if (en) begin
        if (m_slot < 3) begin
          ca[m_slot] = lane_a;
          cb[m_slot] = lane_b;
          m_slot = m_slot + 1;
        end else begin
          m_slot = 0;
          if (!hold) begin
            na = {lane_a, ca[2], ca[1], ca[0]};
            nb = {lane_b, cb[2], cb[1], cb[0]};
            mv = 1;
            mc = (na != fa) || (nb != fb);
            fa = na;
            fb = nb;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nibbles(input string name, input logic [3:0] ea, input logic [3:0] eb);
    view = 1'b0;
    #1 chk({name, "_nib_a"}, 8'(io_out[6:3]), 8'(ea));
    view = 1'b1;
    #1 chk({name, "_nib_b"}, 8'(io_out[6:3]), 8'(eb));
    view = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic hold, valid, chg;
    logic [3:0] nib_a, nib_b;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs = '{
      '{4'hA, 4'h3, 1'b0, 1'b1, 1'b1, 4'hA, 4'h3},
      '{4'hA, 4'h3, 1'b0, 1'b1, 1'b0, 4'hA, 4'h3},
      '{4'hA, 4'h3, 1'b0, 1'b1, 1'b0, 4'hA, 4'h3},
      '{4'h5, 4'h3, 1'b1, 1'b0, 1'b0, 4'hA, 4'h3},
      '{4'h5, 4'h3, 1'b0, 1'b1, 1'b1, 4'h5, 4'h3},
      '{4'h5, 4'hC, 1'b0, 1'b1, 1'b1, 4'h5, 4'hC}
    };
    #1 chk("reset_out", io_out, 8'h00);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_sel", 8'(io_out[1:0]), 8'h00);

    en = 1'b1;
    foreach (vecs[i]) begin
      pat_a = vecs[i].a;
      pat_b = vecs[i].b;
      hold = vecs[i].hold;
      for (int k = 0; k < 4; k++) begin
        step();
        if (k < 3) begin
          chk($sformatf("v%0d_mid_valid", i), 8'(io_out[2]), 8'h00);
          chk($sformatf("v%0d_mid_sel", i), 8'(io_out[1:0]), 8'(k + 1));
        end
      end
      chk($sformatf("v%0d_valid", i), 8'(io_out[2]), 8'(vecs[i].valid));
      chk($sformatf("v%0d_chg", i), 8'(io_out[7]), 8'(vecs[i].chg));
      chk($sformatf("v%0d_sel", i), 8'(io_out[1:0]), 8'h00);
      nibbles($sformatf("v%0d", i), vecs[i].nib_a, vecs[i].nib_b);
    end
    hold = 1'b0;

    pat_a = 4'hA;
    pat_b = 4'h3;
    step();
    step();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("gap_sel", 8'(io_out[1:0]), 8'h02);
      chk("gap_valid", 8'(io_out[2]), 8'h00);
    end
    en = 1'b1;
    step();
    chk("gap_resume_valid", 8'(io_out[2]), 8'h00);
    step();
    chk("gap_valid_end", 8'(io_out[2]), 8'h01);
    chk("gap_chg_end", 8'(io_out[7]), 8'h01);
    nibbles("gap", 4'hA, 4'h3);
    step();
    chk("gap_valid_drop", 8'(io_out[2]), 8'h00);

    pat_a = 4'h0;
    pat_b = 4'h0;
    step();
    chk("abort_sel", 8'(io_out[1:0]), 8'h02);
    rst = 1'b1;
    #1 chk("async_rst_v0", io_out, 8'h00);
    view = 1'b1;
    #1 chk("async_rst_v1", io_out, 8'h00);
    view = 1'b0;
    step();
    rst = 1'b0;
    #1 chk("rst_release_sel", 8'(io_out[1:0]), 8'h00);
    pat_a = 4'hF;
    pat_b = 4'h5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rf_mid_valid", 8'(io_out[2]), 8'h00);
    end
    step();
    chk("rf_valid", 8'(io_out[2]), 8'h01);
    chk("rf_chg", 8'(io_out[7]), 8'h01);
    nibbles("rf", 4'hF, 4'h5);

    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 4) == 0);
      view = 1'($urandom);
      x7 = 1'($urandom);
      pat_a = 4'($urandom);
      pat_b = 4'($urandom);
      if (n % 50 == 7) pat_b = pat_a;
      step();
      chk("rand", io_out, {mc, view ? fb : fa, mv, 2'(m_slot)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
